// File: rtl/pipe_chain_v.sv
// Generic in-order pipeline register chain: DEPTH stages of WIDTH-bit payload with
// valid/ready at both ends, per-stage stall with bubble insertion, ranged flush and CPI counters.
module pipe_chain_v #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 5,
  parameter int CNT_W = 32,
  parameter int SW    = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  input  logic [WIDTH-1:0]       in_data,
  output logic                   in_ready,
  input  logic [DEPTH-1:0]       stall_req,
  input  logic                   flush_en,
  input  logic [SW-1:0]          flush_stage,
  output logic                   out_valid,
  output logic [WIDTH-1:0]       out_data,
  input  logic                   out_ready,
  output logic [DEPTH-1:0]       stage_valid,
  output logic [DEPTH*WIDTH-1:0] stage_data,
  output logic [CNT_W-1:0]       retired_cnt,
  output logic [CNT_W-1:0]       bubble_cnt,
  output logic [CNT_W-1:0]       flush_cnt
);

  localparam logic [31:0] LAST = 32'(DEPTH - 1);

  logic [DEPTH-1:0] valid_r;
  logic [WIDTH-1:0] data_r [DEPTH];
  logic [DEPTH:0]   take_s;
  logic [DEPTH-1:0] move_s;
  logic [DEPTH-1:0] flush_mask_s;
  logic [31:0]      fs_ext_s;
  logic             full_flush_s;
  logic             accept_s;
  logic             retire_s;

  // Take chain: a stage can take a new entry if it is empty or its entry moves on.
  always_comb begin
    take_s = '0;
    move_s = '0;
    take_s[DEPTH] = out_ready;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      move_s[k] = valid_r[k] & ~stall_req[k] & take_s[k+1];
      take_s[k] = ~valid_r[k] | move_s[k];
    end
  end

  // Flush covers stages 0..flush_stage; an index at or past the last stage flushes everything.
  always_comb begin
    fs_ext_s     = 32'(flush_stage);
    flush_mask_s = '0;
    for (int k = 0; k < DEPTH; k++) begin
      flush_mask_s[k] = flush_en & (fs_ext_s >= 32'(k));
    end
    full_flush_s = flush_en & (fs_ext_s >= LAST);
  end

  assign in_ready    = take_s[0] & ~flush_en;
  assign out_valid   = valid_r[DEPTH-1] & ~stall_req[DEPTH-1];
  assign out_data    = data_r[DEPTH-1];
  assign stage_valid = valid_r;
  assign accept_s    = in_valid & in_ready;
  assign retire_s    = out_valid & out_ready & ~full_flush_s;

  // Export per-stage payloads, stage k in slice k.
  always_comb begin
    stage_data = '0;
    for (int k = 0; k < DEPTH; k++) begin
      stage_data[k*WIDTH +: WIDTH] = data_r[k];
    end
  end

  // Stage registers; a stage fed by the last flushed stage gets a bubble instead of its data.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_r <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        data_r[k] <= '0;
      end
    end else begin
      if (flush_mask_s[0]) begin
        valid_r[0] <= 1'b0;
      end else if (accept_s) begin
        valid_r[0] <= 1'b1;
        data_r[0]  <= in_data;
      end else if (move_s[0]) begin
        valid_r[0] <= 1'b0;
      end
      for (int k = 1; k < DEPTH; k++) begin
        if (flush_mask_s[k]) begin
          valid_r[k] <= 1'b0;
        end else if (move_s[k-1] & ~flush_mask_s[k-1]) begin
          valid_r[k] <= 1'b1;
          data_r[k]  <= data_r[k-1];
        end else if (move_s[k]) begin
          valid_r[k] <= 1'b0;
        end
      end
    end
  end

  // CPI counters, free-running and wrapping.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      retired_cnt <= '0;
      bubble_cnt  <= '0;
      flush_cnt   <= '0;
    end else begin
      if (retire_s) begin
        retired_cnt <= retired_cnt + CNT_W'(1'b1);
      end
      if (!valid_r[DEPTH-1]) begin
        bubble_cnt <= bubble_cnt + CNT_W'(1'b1);
      end
      if (flush_en) begin
        flush_cnt <= flush_cnt + CNT_W'(1'b1);
      end
    end
  end

endmodule

// File: tb/tb_pipe_chain_v.sv
// Directed bench for pipe_chain_v: table of per-cycle vectors for streaming, stall and
// backpressure, then hand-written flush, counter-wrap and async-reset sequences.
module tb_pipe_chain_v;

  logic         clk;
  logic         reset;
  logic         in_valid;
  logic [31:0]  in_data;
  logic [4:0]   stall_req;
  logic         flush_en;
  logic [2:0]   flush_stage;
  logic         out_ready;

  logic         in_ready, out_valid;
  logic [31:0]  out_data;
  logic [4:0]   stage_valid;
  logic [159:0] stage_data;
  logic [31:0]  retired_cnt, bubble_cnt, flush_cnt;

  logic         in_ready4, out_valid4;
  logic [31:0]  out_data4;
  logic [4:0]   stage_valid4;
  logic [159:0] stage_data4;
  logic [3:0]   retired_cnt4, bubble_cnt4, flush_cnt4;

  int tests = 0;
  int fails = 0;

  pipe_chain_v #(.WIDTH(32), .DEPTH(5), .CNT_W(32)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .stall_req(stall_req), .flush_en(flush_en), .flush_stage(flush_stage),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .stage_valid(stage_valid), .stage_data(stage_data),
    .retired_cnt(retired_cnt), .bubble_cnt(bubble_cnt), .flush_cnt(flush_cnt)
  );

  pipe_chain_v #(.WIDTH(32), .DEPTH(5), .CNT_W(4)) dut4 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready4),
    .stall_req(stall_req), .flush_en(flush_en), .flush_stage(flush_stage),
    .out_valid(out_valid4), .out_data(out_data4), .out_ready(out_ready),
    .stage_valid(stage_valid4), .stage_data(stage_data4),
    .retired_cnt(retired_cnt4), .bubble_cnt(bubble_cnt4), .flush_cnt(flush_cnt4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        iv;
    logic [31:0] id;
    logic        ordy;
    logic [4:0]  st;
    logic [4:0]  sv;
    logic        ir;
    logic        ov;
    logic [31:0] od;
    logic [31:0] s0;
    logic [7:0]  ret;
    logic [7:0]  bub;
  } vec_t;

  vec_t vecs [16];

  function automatic vec_t mk(input logic iv, input logic [31:0] id, input logic ordy,
                              input logic [4:0] st, input logic [4:0] sv, input logic ir,
                              input logic ov, input logic [31:0] od, input logic [31:0] s0,
                              input logic [7:0] ret, input logic [7:0] bub);
    vec_t v;
    v = '{iv: iv, id: id, ordy: ordy, st: st, sv: sv, ir: ir, ov: ov, od: od, s0: s0,
          ret: ret, bub: bub};
    return v;
  endfunction

  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    in_valid    = 1'b0;
    in_data     = 32'h0;
    stall_req   = 5'b00000;
    flush_en    = 1'b0;
    flush_stage = 3'd0;
    out_ready   = 1'b0;
  endtask

  int exp_idx;

  initial begin
    // streaming, stall on stage 2, then 3 cycles of sink backpressure
    vecs[0]  = mk(1'b1, 32'h10, 1'b1, 5'b00000, 5'b00000, 1'b1, 1'b0, 32'h00, 32'h00, 8'd0, 8'd0);
    vecs[1]  = mk(1'b1, 32'h11, 1'b1, 5'b00000, 5'b00001, 1'b1, 1'b0, 32'h00, 32'h10, 8'd0, 8'd1);
    vecs[2]  = mk(1'b1, 32'h12, 1'b1, 5'b00000, 5'b00011, 1'b1, 1'b0, 32'h00, 32'h11, 8'd0, 8'd2);
    vecs[3]  = mk(1'b1, 32'h13, 1'b1, 5'b00000, 5'b00111, 1'b1, 1'b0, 32'h00, 32'h12, 8'd0, 8'd3);
    vecs[4]  = mk(1'b1, 32'h14, 1'b1, 5'b00000, 5'b01111, 1'b1, 1'b0, 32'h00, 32'h13, 8'd0, 8'd4);
    vecs[5]  = mk(1'b1, 32'h15, 1'b1, 5'b00000, 5'b11111, 1'b1, 1'b1, 32'h10, 32'h14, 8'd0, 8'd5);
    vecs[6]  = mk(1'b1, 32'h16, 1'b1, 5'b00000, 5'b11111, 1'b1, 1'b1, 32'h11, 32'h15, 8'd1, 8'd5);
    vecs[7]  = mk(1'b1, 32'h17, 1'b1, 5'b00100, 5'b11111, 1'b0, 1'b1, 32'h12, 32'h16, 8'd2, 8'd5);
    vecs[8]  = mk(1'b1, 32'h17, 1'b1, 5'b00100, 5'b10111, 1'b0, 1'b1, 32'h13, 32'h16, 8'd3, 8'd5);
    vecs[9]  = mk(1'b1, 32'h17, 1'b1, 5'b00000, 5'b00111, 1'b1, 1'b0, 32'h00, 32'h16, 8'd4, 8'd5);
    vecs[10] = mk(1'b1, 32'h18, 1'b1, 5'b00000, 5'b01111, 1'b1, 1'b0, 32'h00, 32'h17, 8'd4, 8'd6);
    vecs[11] = mk(1'b1, 32'h19, 1'b1, 5'b00000, 5'b11111, 1'b1, 1'b1, 32'h14, 32'h18, 8'd4, 8'd7);
    vecs[12] = mk(1'b1, 32'h1A, 1'b0, 5'b00000, 5'b11111, 1'b0, 1'b1, 32'h15, 32'h19, 8'd5, 8'd7);
    vecs[13] = mk(1'b1, 32'h1A, 1'b0, 5'b00000, 5'b11111, 1'b0, 1'b1, 32'h15, 32'h19, 8'd5, 8'd7);
    vecs[14] = mk(1'b1, 32'h1A, 1'b0, 5'b00000, 5'b11111, 1'b0, 1'b1, 32'h15, 32'h19, 8'd5, 8'd7);
    vecs[15] = mk(1'b1, 32'h1A, 1'b1, 5'b00000, 5'b11111, 1'b1, 1'b1, 32'h15, 32'h19, 8'd5, 8'd7);

    idle_inputs();
    reset = 1'b0;
    #12;
    chk("reset stage_valid", 160'(stage_valid), 160'(5'b00000));
    chk("reset out_valid", 160'(out_valid), 160'(1'b0));
    chk("reset in_ready", 160'(in_ready), 160'(1'b1));
    chk("reset counters", {retired_cnt, bubble_cnt, flush_cnt}, 160'(0));
    reset = 1'b1;

    for (int i = 0; i < 16; i++) begin
      in_valid  = vecs[i].iv;
      in_data   = vecs[i].id;
      out_ready = vecs[i].ordy;
      stall_req = vecs[i].st;
      #1;
      chk($sformatf("r%0d stage_valid", i), 160'(stage_valid), 160'(vecs[i].sv));
      chk($sformatf("r%0d in_ready", i), 160'(in_ready), 160'(vecs[i].ir));
      chk($sformatf("r%0d out_valid", i), 160'(out_valid), 160'(vecs[i].ov));
      if (vecs[i].ov) chk($sformatf("r%0d out_data", i), 160'(out_data), 160'(vecs[i].od));
      if (vecs[i].sv[0]) chk($sformatf("r%0d stage0", i), 160'(stage_data[31:0]), 160'(vecs[i].s0));
      chk($sformatf("r%0d retired_cnt", i), 160'(retired_cnt), 160'(vecs[i].ret));
      chk($sformatf("r%0d bubble_cnt", i), 160'(bubble_cnt), 160'(vecs[i].bub));
      step();
    end

    // asynchronous reset in the middle of a full stream, no clock edge in between
    reset = 1'b0;
    #1;
    chk("async rst stage_valid", 160'(stage_valid), 160'(5'b00000));
    chk("async rst out", {out_valid, out_data}, 160'(0));
    chk("async rst stage_data", stage_data, 160'(0));
    chk("async rst counters", {retired_cnt, bubble_cnt, flush_cnt}, 160'(0));
    #1;
    reset = 1'b1;
    idle_inputs();

    // fill A..E with sink blocked, then flush stages 0..2 while A retires
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_data  = 32'hA0 + 32'(i);
      #1;
      chk($sformatf("fill%0d in_ready", i), 160'(in_ready), 160'(1'b1));
      step();
    end
    chk("fill stage_valid", 160'(stage_valid), 160'(5'b11111));
    chk("fill out_data", 160'(out_data), 160'(32'hA0));
    in_data     = 32'hEE;
    flush_en    = 1'b1;
    flush_stage = 3'd2;
    out_ready   = 1'b1;
    #1;
    chk("flush2 in_ready", 160'(in_ready), 160'(1'b0));
    chk("flush2 out_valid", 160'(out_valid), 160'(1'b1));
    step();
    idle_inputs();
    #1;
    chk("flush2 stage_valid", 160'(stage_valid), 160'(5'b10000));
    chk("flush2 keeps B", 160'(out_data), 160'(32'hA1));
    chk("flush2 flush_cnt", 160'(flush_cnt), 160'(1));
    chk("flush2 retired_cnt", 160'(retired_cnt), 160'(1));

    // full flush beats a full stall
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_data  = 32'hB0 + 32'(i);
      step();
    end
    in_valid = 1'b0;
    #1;
    chk("pre-flush4 stage_valid", 160'(stage_valid), 160'(5'b10111));
    stall_req   = 5'b11111;
    flush_en    = 1'b1;
    flush_stage = 3'd4;
    out_ready   = 1'b1;
    #1;
    chk("flush4 out_valid", 160'(out_valid), 160'(1'b0));
    step();
    idle_inputs();
    #1;
    chk("flush4 stage_valid", 160'(stage_valid), 160'(5'b00000));
    chk("flush4 retired_cnt", 160'(retired_cnt), 160'(1));
    chk("flush4 flush_cnt", 160'(flush_cnt), 160'(2));

    // full flush with a retire-ready oldest entry: retire must not count
    in_valid = 1'b1;
    in_data  = 32'hC0;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) step();
    chk("pre-flush6 stage_valid", 160'(stage_valid), 160'(5'b10000));
    chk("pre-flush6 out_data", 160'(out_data), 160'(32'hC0));
    flush_en    = 1'b1;
    flush_stage = 3'd6;
    out_ready   = 1'b1;
    #1;
    chk("flush6 out_valid", 160'(out_valid), 160'(1'b1));
    step();
    idle_inputs();
    #1;
    chk("flush6 stage_valid", 160'(stage_valid), 160'(5'b00000));
    chk("flush6 retired_cnt", 160'(retired_cnt), 160'(1));
    chk("flush6 flush_cnt", 160'(flush_cnt), 160'(3));

    // 16 retires after reset: 4-bit counter wraps, order preserved
    reset = 1'b0;
    #1;
    reset = 1'b1;
    exp_idx = 0;
    for (int n = 0; n < 21; n++) begin
      in_valid  = (n < 16);
      in_data   = 32'h40 + 32'(n);
      out_ready = 1'b1;
      #1;
      if (out_valid) begin
        chk($sformatf("stream out_data %0d", exp_idx), 160'(out_data), 160'(32'h40 + 32'(exp_idx)));
        exp_idx++;
      end
      step();
    end
    chk("stream retire count", 160'(exp_idx), 160'(16));
    chk("wide retired_cnt", 160'(retired_cnt), 160'(16));
    chk("narrow retired_cnt wrap", 160'(retired_cnt4), 160'(4'd0));
    chk("stream bubble_cnt", 160'(bubble_cnt), 160'(5));

    // reset again mid-stream
    for (int n = 0; n < 3; n++) begin
      in_valid = 1'b1;
      in_data  = 32'h60 + 32'(n);
      step();
    end
    reset = 1'b0;
    #1;
    chk("async rst2 stage_valid", 160'(stage_valid), 160'(5'b00000));
    chk("async rst2 retired", {retired_cnt, 28'h0, retired_cnt4}, 160'(0));
    chk("async rst2 stage_data", stage_data, 160'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pipe_chain_v.md
Name: pipe_chain_v

Overview:
- Parametrised, generic in-order pipeline register chain. It replaces hand-wired per-stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB) with one block of DEPTH stages, each carrying a WIDTH-bit payload.
- Adds what the fixed registers lack:
  - valid/ready backpressure at both ends;
  - per-stage stall with automatic bubble insertion;
  - ranged flush;
  - retire, bubble and flush counters for CPI measurement.
- Sits between the fetch source and the retire sink of the CPU top level. Per-stage payloads are exported to stage logic.

Parameters:
- WIDTH, 32, payload bits per stage
- DEPTH, 5, number of stages (>=2); stage 0 youngest, stage DEPTH-1 oldest
- CNT_W, 32, counter width
- SW, $clog2(DEPTH), width of the flush stage index

Ports:
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-low reset
- in_valid  in  1  new entry offered to stage 0
- in_data  in  WIDTH  entry payload
- in_ready  out  1  stage 0 can accept this cycle
- stall_req  in  DEPTH  bit k=1 holds stage k this cycle
- flush_en  in  1  flush request
- flush_stage  in  SW  flush stages 0..flush_stage inclusive
- out_valid  out  1  oldest stage presents an entry
- out_data  out  WIDTH  oldest stage payload
- out_ready  in  1  sink accepts (retire)
- stage_valid  out  DEPTH  valid bit per stage
- stage_data  out  DEPTH*WIDTH  payload per stage, stage k at [k*WIDTH +: WIDTH]
- retired_cnt  out  CNT_W  entries retired
- bubble_cnt  out  CNT_W  cycles with stage DEPTH-1 invalid
- flush_cnt  out  CNT_W  flush events

Behaviour:

Reset (reset=0, asynchronous):
- All valid bits, payloads and counters are 0.
- out_valid=0.
- in_ready follows its combinational equation.

Advance chain (combinational):
- take[DEPTH] = out_ready.
- move[k] = valid[k] & ~stall_req[k] & take[k+1].
- take[k] = ~valid[k] | move[k].
- in_ready = take[0] & ~flush_en.
- out_valid = valid[DEPTH-1] & ~stall_req[DEPTH-1].
- out_data = data[DEPTH-1].
- Retire = out_valid & out_ready.

Clock edge without flush:
- Stage 0 loads in_data with valid=1 when in_valid & in_ready.
- Otherwise, if move[0]=1, stage 0 becomes valid=0.
- Otherwise stage 0 holds.
- Stage k>0 loads data[k-1] with valid=1 when move[k-1].
- Otherwise, if move[k]=1, stage k becomes valid=0 (bubble).
- Otherwise stage k holds.
- Stalled stage k holds; every younger stage whose take chain is blocked also holds.
- An older empty stage downstream of a stall receives a bubble.
- Payload of an invalidated stage is don't-care and is held, not cleared.

Flush (synchronous, flush_en=1):
- Stages 0..flush_stage become valid=0 at the edge, regardless of stall_req.
- in_ready=0, so no input is accepted that cycle.
- Stage flush_stage+1 (if it exists) receives a bubble instead of data[flush_stage].
- Stages > flush_stage+1 advance normally.
- flush_stage >= DEPTH-1 flushes every stage, and nothing retires that cycle: out_valid is still asserted combinationally, but the retire counter is gated by ~(flush_en & flush_stage>=DEPTH-1).

Counters:
- retired_cnt +1 per counted retire.
- bubble_cnt +1 per cycle with valid[DEPTH-1]=0.
- flush_cnt +1 per cycle with flush_en=1.
- All counters wrap modulo 2^CNT_W; no saturation.

Other rules:
- Simultaneous stall_req[k] and flush covering k: the flush wins.
- Full chain with out_ready=0: in_ready=0, all stages hold.

Test Plan (DEPTH=5, WIDTH=32):
1. Reset low, then release; feed 0x10,0x11,0x12… one per cycle with out_ready=1 -> out_data=0x10 valid 5 cycles after first accept; one retire per cycle thereafter; bubble_cnt=5 at first retire.
2. Steady stream, stall_req=5'b00100 for 2 cycles -> stages 0–2 hold, stage 3 shows valid=0 twice, retired stream has no gaps other than those bubbles, no lost or duplicated values.
3. Full chain, out_ready=0 for 3 cycles -> in_ready=0, stage_data unchanged, retired_cnt unchanged; on out_ready=1, retire resumes in order.
4. Entries A..E occupy stages 4..0 (A oldest, in stage 4), flush_en=1, flush_stage=2 -> next cycle stage_valid=5'b10000 with B retained (A retires when out_ready=1), flush_cnt=1, input accept blocked that cycle.
5. flush_en with flush_stage=4 while stall_req=5'b11111 -> all valid=0 next cycle, retired_cnt unchanged.
6. CNT_W=4, 16 retires -> retired_cnt wraps to 0; assert reset mid-stream -> all outputs 0 immediately, asynchronously, without waiting for clk.
